// File: rtl/mod_counter.sv
// Presettable modulo counter with prescaled enable, up/down direction, runtime modulus,
// synchronous clear/load and wrap or one-shot terminal behaviour.
module mod_counter #(
    parameter int unsigned WIDTH    = 28,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             step;
    logic             terminal;

    always_comb begin
        pre_d    = pre_q;
        count_d  = count_q;
        tc_d     = 1'b0;
        done_d   = done_q;
        step     = 1'b0;
        terminal = dir ? (count_q >= modulus) : (count_q == '0);

        if (clr) begin
            pre_d   = '0;
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            pre_d   = '0;
            count_d = load_val;
            done_d  = 1'b0;
        end else if (en) begin
            if (pre_q == PreMax) begin
                pre_d = '0;
                step  = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        // Terminal detection precedes the +/-1, so the arithmetic never overflows.
        if (step && !done_q) begin
            if (terminal) begin
                tc_d = 1'b1;
                if (mode) begin
                    done_d = 1'b1;
                end else begin
                    count_d = dir ? '0 : modulus;
                end
            end else begin
                count_d = dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: one instance with PRESCALE=1 and one with PRESCALE=4,
// both WIDTH=8, sharing the same stimulus.
module tb_mod_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       dir;
    logic       mode;
    logic [7:0] modulus;
    logic [7:0] count1, count4;
    logic       tc1, tc4;
    logic       done1, done4;

    int checks;
    int errors;

    mod_counter #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .modulus  (modulus),
        .count    (count1),
        .tc       (tc1),
        .done     (done1)
    );

    mod_counter #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .modulus  (modulus),
        .count    (count4),
        .tc       (tc4),
        .done     (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        modulus  = 8'hFF;
        dir      = 1'b1;
        mode     = 1'b0;
        load_val = 8'h5A;
        load     = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count1 !== 8'h5A) begin
            errors++;
            $display("FAIL reset_preload count=%0h exp=5a", count1);
        end
        en = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count1 !== 8'h00 || tc1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async count=%0h tc=%b done=%b exp=0/0/0", count1, tc1, done1);
        end
        checks++;
        if (count4 !== 8'h00 || tc4 !== 1'b0 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_p4 count=%0h tc=%b done=%b exp=0/0/0", count4, tc4, done4);
        end
        #1;
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (count1 !== 8'h00 || tc1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d] count=%0h tc=%b exp=0/0", i, count1, tc1);
            end
        end
    endtask

    task automatic test_up_wrap();
        int exp_c[5] = '{1, 2, 3, 0, 1};
        int exp_t[5] = '{0, 0, 0, 1, 0};
        modulus = 8'd3;
        dir     = 1'b1;
        mode    = 1'b0;
        clr     = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (count1 !== 8'd0) begin
            errors++;
            $display("FAIL up_wrap_start count=%0d exp=0", count1);
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (count1 !== 8'(exp_c[i]) || tc1 !== 1'(exp_t[i])) begin
                errors++;
                $display("FAIL up_wrap[%0d] count=%0d tc=%b exp=%0d/%0d",
                         i, count1, tc1, exp_c[i], exp_t[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_prescale();
        int exp_c[8] = '{1, 1, 1, 0, 0, 0, 0, 2};
        int exp_t[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        int en_p[7]  = '{1, 1, 0, 0, 0, 1, 1};
        int exp_p[7] = '{2, 2, 2, 2, 2, 2, 1};
        modulus  = 8'd2;
        dir      = 1'b0;
        mode     = 1'b0;
        load_val = 8'd1;
        load     = 1'b1;
        tick();
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (count4 !== 8'(exp_c[i]) || tc4 !== 1'(exp_t[i])) begin
                errors++;
                $display("FAIL down_p4[%0d] count=%0d tc=%b exp=%0d/%0d",
                         i, count4, tc4, exp_c[i], exp_t[i]);
            end
        end
        for (int i = 0; i < 7; i++) begin
            en = 1'(en_p[i]);
            tick();
            checks++;
            if (count4 !== 8'(exp_p[i]) || tc4 !== 1'b0) begin
                errors++;
                $display("FAIL down_p4_pause[%0d] count=%0d tc=%b exp=%0d/0",
                         i, count4, tc4, exp_p[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_one_shot();
        int exp_c[8] = '{1, 2, 3, 4, 5, 5, 5, 5};
        int exp_t[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        int exp_d[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        modulus = 8'd5;
        mode    = 1'b1;
        dir     = 1'b1;
        en      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (count1 !== 8'(exp_c[i]) || tc1 !== 1'(exp_t[i]) || done1 !== 1'(exp_d[i])) begin
                errors++;
                $display("FAIL one_shot[%0d] count=%0d tc=%b done=%b exp=%0d/%0d/%0d",
                         i, count1, tc1, done1, exp_c[i], exp_t[i], exp_d[i]);
            end
        end
        load_val = 8'd2;
        load     = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count1 !== 8'd2 || done1 !== 1'b0 || tc1 !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_reload count=%0d done=%b tc=%b exp=2/0/0", count1, done1, tc1);
        end
        tick();
        checks++;
        if (count1 !== 8'd3 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_resume count=%0d done=%b exp=3/0", count1, done1);
        end
        en   = 1'b0;
        mode = 1'b0;
    endtask

    task automatic test_priority();
        modulus  = 8'd3;
        dir      = 1'b1;
        mode     = 1'b0;
        load_val = 8'd3;
        load     = 1'b1;
        tick();
        // Count sits at the terminal value, so an unblocked step would wrap with tc.
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 8'd7;
        en       = 1'b1;
        tick();
        checks++;
        if (count1 !== 8'd0 || tc1 !== 1'b0) begin
            errors++;
            $display("FAIL prio_clr count=%0d tc=%b exp=0/0", count1, tc1);
        end
        clr = 1'b0;
        tick();
        checks++;
        if (count1 !== 8'd7 || tc1 !== 1'b0) begin
            errors++;
            $display("FAIL prio_load count=%0d tc=%b exp=7/0", count1, tc1);
        end
        load = 1'b0;
        en   = 1'b0;
    endtask

    task automatic test_back_to_back();
        modulus  = 8'd4;
        dir      = 1'b1;
        mode     = 1'b0;
        load_val = 8'd9;
        load     = 1'b1;
        tick();
        load = 1'b0;
        en   = 1'b1;
        tick();
        checks++;
        if (count1 !== 8'd0 || tc1 !== 1'b1) begin
            errors++;
            $display("FAIL oor_up count=%0d tc=%b exp=0/1", count1, tc1);
        end
        en   = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        dir  = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (count1 !== 8'(8 - i) || tc1 !== 1'b0) begin
                errors++;
                $display("FAIL oor_down[%0d] count=%0d tc=%b exp=%0d/0", i, count1, tc1, 8 - i);
            end
        end
        tick();
        checks++;
        if (count1 !== 8'd4 || tc1 !== 1'b1) begin
            errors++;
            $display("FAIL oor_down_wrap count=%0d tc=%b exp=4/1", count1, tc1);
        end
        en      = 1'b0;
        modulus = 8'd0;
        dir     = 1'b1;
        clr     = 1'b1;
        tick();
        clr = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dir = (i < 3) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if (count1 !== 8'd0 || tc1 !== 1'b1) begin
                errors++;
                $display("FAIL mod0[%0d] count=%0d tc=%b exp=0/1", i, count1, tc1);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        dir      = 1'b1;
        mode     = 1'b0;
        modulus  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        test_reset();
        test_up_wrap();
        test_down_prescale();
        test_one_shot();
        test_priority();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised, presettable modulo counter replacing the free-running 28-bit counter used for clock division and timing on the Basys3 designs. It adds asynchronous active-low reset, an enable with a built-in prescaler, up/down direction, a runtime modulus, synchronous clear and load, and a wrap or one-shot mode. It sits directly on the board clock and feeds LED blinkers, display multiplexers and debounce timers through `count`, `tc` and `done`.

## Interface
- `WIDTH`, default 28: count register width in bits.
- `PRESCALE`, default 1: number of enabled clocks per count step. Must be at least 1. The prescaler width is `$clog2(PRESCALE)`, with a minimum of 1.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: count enable. When low, it freezes both the prescaler and the count.
- `clr` input 1: synchronous clear.
- `load` input 1: synchronous load of `load_val`.
- `load_val` input WIDTH: preset value.
- `dir` input 1: 1 counts up, 0 counts down.
- `mode` input 1: 0 selects wrap, 1 selects one-shot.
- `modulus` input WIDTH: top of the count range, so the range is 0..modulus inclusive.
- `count` output WIDTH: current count, registered.
- `tc` output 1: terminal-count pulse, registered, one cycle wide.
- `done` output 1: one-shot finished flag, registered, sticky.

## Operation
- Reset (`rst_n` = 0, asynchronous): `count`=0, prescaler=0, `tc`=0, `done`=0. These values hold until the first rising edge after `rst_n` is released. Reset may be asserted at any time, including mid-count, and takes effect immediately.
- Per-edge priority is `clr` > `load` > step.
  - `clr`: `count`←0, prescaler←0, `done`←0, `tc`←0.
  - `load`: `count`←`load_val`, prescaler←0, `done`←0, `tc`←0. The value is loaded unclamped, even if it is greater than `modulus`.
- Prescaler: when `en`=1 and neither `clr` nor `load` is active, it increments. When it equals PRESCALE-1, it returns to 0 and a step occurs on that edge. With PRESCALE=1, every enabled cycle is a step.
- Terminal value T:
  - Up: the count is terminal when `count` >= `modulus` (unsigned compare).
  - Down: the count is terminal when `count` == 0.
- Step while `done`=1: the step is ignored. The count, `tc` and `done` are all unchanged, and `tc` is 0.
- Non-terminal step: `count` ← `count`+1 (up) or `count`−1 (down). `tc`←0.
- Terminal step in wrap mode: `count` ← 0 (up) or `modulus` (down). `tc`←1.
- Terminal step in one-shot mode: `count` is unchanged, `done`←1, `tc`←1. Further steps are ignored until `clr` or `load`.
- Any edge without a step: `tc`←0.
- Down count from a value above `modulus`: decrements normally toward 0, with no clamp.
- `modulus`=0:
  - Up: every step is terminal, so `count` stays at 0 (wrap) and `tc` pulses on every step.
  - Down: the same applies.
- `dir`, `mode` and `modulus` may change at any time. They are sampled on each step edge, with no internal latching.
- Arithmetic is unsigned modulo 2^WIDTH. No step can overflow, because terminal detection precedes the increment and decrement.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- A step edge updates `count` and `tc` together. `tc` is high for exactly one clock, in the same cycle `count` shows its post-wrap value.
- Step latency:
  - From the first enabled cycle after clear, load or reset, the first step occurs on the PRESCALE-th enabled edge.
  - While `en` stays high, steps occur every PRESCALE clocks.
- Deasserting `en` holds the prescaler phase. Reasserting `en` resumes from that phase.
- `clr` or `load` asserted on a would-be step edge suppresses the step and the `tc` pulse.
- `done` asserts on the terminal edge, together with `tc`, and clears on the next `clr`/`load` edge or on reset.

## Test plan
- Reset and hold: assert `rst_n`=0 mid-count with `count`=0x5A → `count`=0, `tc`=0, `done`=0 immediately, without waiting for a clock edge. After release with `en`=0 for 10 cycles → `count` stays at 0.
- Up wrap (WIDTH=8, PRESCALE=1, `modulus`=3, `dir`=1, `mode`=0): `count` sequence is 0,1,2,3,0,1. `tc` is high only in the cycle showing the 0 after the 3.
- Down wrap with prescale (PRESCALE=4, `modulus`=2, `dir`=0, load 1): `count` goes 1→0→2, with exactly 4 clocks between changes. `tc` is high for one cycle when `count` becomes 2. Dropping `en` for 3 cycles mid-phase delays the next change by exactly 3 clocks.
- One-shot (PRESCALE=1, `modulus`=5, `mode`=1, `dir`=1): `count` goes 0..5, then holds at 5. `tc` and `done` both go high on the step taken at `count`=5, `tc` for one cycle and `done` sticky. Then `load` with `load_val`=2 → `count`=2, `done`=0, and counting resumes.
- Priority: in the same cycle assert `clr`=1, `load`=1, `load_val`=0x7 and a pending step → `count`=0 and `tc`=0. Next, `load`=1 alone → `count`=7.
- Out-of-range and edge modulus: load 9 with `modulus`=4 and `dir`=1 → the next step wraps to 0 with a `tc` pulse. Load 9 with `dir`=0 → `count` goes 8,7,…,0, then 4. With `modulus`=0 and `dir`=1 → `count` stays at 0 and `tc` pulses on every step.
